// File: rtl/matdet_pkg.sv
// Shared definitions for the sequential determinant engine: FSM encoding,
// legal matrix orders and helpers for Lehmer-digit / column-index widths.
package matdet_pkg;

    localparam int MIN_N = 2;
    localparam int MAX_N = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lehmer digits and column indices both range over 0..N-1.
    function automatic int digit_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int fact(input int n);
        case (n)
            2:       return 2;
            3:       return 6;
            4:       return 24;
            5:       return 120;
            6:       return 720;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/matdet_perm_decode.sv
// Lehmer digits -> permutation columns and sign. Digit k selects the d[k]-th
// still-unused column in ascending order; sign is the parity of the digit sum.
module matdet_perm_decode
    import matdet_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = digit_w(N)
) (
    input  logic [W-1:0] digits [N],
    output logic [W-1:0] cols   [N],
    output logic         neg
);

    // NOTE: every variable written in always_comb gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        logic [N-1:0] used;
        logic [W-1:0] cnt;
        logic         found;
        used = '0;
        neg  = 1'b0;
        for (int k = 0; k < N; k++) begin
            cols[k] = '0;
            cnt     = '0;
            found   = 1'b0;
            for (int c = 0; c < N; c++) begin
                if (!used[c]) begin
                    if (!found && cnt == digits[k]) begin
                        cols[k] = W'(c);
                        used[c] = 1'b1;
                        found   = 1'b1;
                    end
                    cnt = cnt + 1'b1;
                end
            end
            // Sum of Lehmer digits equals the inversion count.
            neg = neg ^ digits[k][0];
        end
    end

endmodule

// File: rtl/matdet_seq.sv
// Sequential NxN determinant (Leibniz expansion) with one shared multiplier:
// one row-cycle per permutation term, N!*N cycles per matrix, mod 2^DATA_WIDTH.
module matdet_seq
    import matdet_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*N*DATA_WIDTH-1:0]    a,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        det
);

    localparam int DW = DATA_WIDTH;
    localparam int W  = digit_w(N);
    localparam logic [W-1:0] LAST_ROW = W'(N - 1);

    if (N < MIN_N || N > MAX_N) begin : g_bad_n
        $error("matdet_seq: N must be in 2..6");
    end

    state_t          state, state_nxt;
    logic [DW-1:0]   mat     [N][N];
    logic [W-1:0]    lehmer  [N];
    logic [W-1:0]    lehmer_nxt [N];
    logic [W-1:0]    cols    [N];
    logic            neg;
    logic [W-1:0]    row;
    logic [W-1:0]    col_j;
    logic [DW-1:0]   elem, product, prod, acc, acc_nxt;
    logic            accept, last_row, last_perm, carry;

    matdet_perm_decode #(.N(N)) u_decode (
        .digits (lehmer),
        .cols   (cols),
        .neg    (neg)
    );

    assign accept = in_valid && in_ready;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)              state_nxt = RUN;
            RUN:     if (last_row && last_perm) state_nxt = DONE;
            DONE:    if (out_ready)             state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // ---------------- datapath combinational ----------------
    always_comb begin
        col_j    = cols[row];
        elem     = mat[row][col_j];
        product  = prod * elem;
        acc_nxt  = neg ? (acc - product) : (acc + product);
        last_row = (row == LAST_ROW);

        // Mixed-radix increment, digit N-2 fastest; digit N-1 is always zero.
        lehmer_nxt = lehmer;
        carry      = 1'b1;
        last_perm  = 1'b1;
        for (int k = N - 2; k >= 0; k--) begin
            if (lehmer[k] != W'(N - 1 - k)) last_perm = 1'b0;
            if (carry) begin
                if (lehmer[k] == W'(N - 1 - k)) begin
                    lehmer_nxt[k] = '0;
                end else begin
                    lehmer_nxt[k] = lehmer[k] + 1'b1;
                    carry         = 1'b0;
                end
            end
        end
    end

    // NOTE: the matrix store has no reset; it is always written on accept
    // before any read, so reset would only add fan-out on a wide register.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    mat[r][c] <= a[(r*N + c)*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
            acc  <= '0;
            row  <= '0;
            det  <= '0;
            for (int k = 0; k < N; k++) lehmer[k] <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    prod <= '0;
                    acc  <= '0;
                    row  <= '0;
                    for (int k = 0; k < N; k++) lehmer[k] <= '0;
                end
                RUN: if (last_row) begin
                    acc    <= acc_nxt;
                    row    <= '0;
                    lehmer <= lehmer_nxt;
                    if (last_perm) det <= acc_nxt;
                end else begin
                    prod <= (row == '0) ? elem : product;
                    row  <= row + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matdet_seq.sv
// Bench for matdet_seq: five instances (N=2..5 at 8 bits, N=4 at 16 bits),
// scoreboard of expected determinants, directed corner cases plus random vectors.
module tb_matdet_seq;

    typedef int mat_t [6][6];
    typedef struct {
        int     sel;
        longint det;
        int     lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          t0 [5];
    int          hs_cyc = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [5];
    logic        out_ready [5];
    logic [599:0] a_bus    [5];
    logic        in_ready  [5];
    logic        out_valid [5];
    logic [7:0]  det8 [4];
    logic [15:0] det16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matdet_seq #(.DATA_WIDTH(8), .N(2)) u_n2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_bus[0][31:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .det(det8[0]));
    matdet_seq #(.DATA_WIDTH(8), .N(3)) u_n3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_bus[1][71:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .det(det8[1]));
    matdet_seq #(.DATA_WIDTH(8), .N(4)) u_n4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_bus[2][127:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .det(det8[2]));
    matdet_seq #(.DATA_WIDTH(8), .N(5)) u_n5 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a_bus[3][199:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .det(det8[3]));
    matdet_seq #(.DATA_WIDTH(16), .N(4)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
        .a(a_bus[4][255:0]), .out_valid(out_valid[4]), .out_ready(out_ready[4]), .det(det16));

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int n_of(input int sel);
        case (sel)
            0: return 2;
            1: return 3;
            3: return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int dw_of(input int sel);
        return (sel == 4) ? 16 : 8;
    endfunction

    function automatic int fact_i(input int n);
        int f = 1;
        for (int i = 2; i <= n; i++) f *= i;
        return f;
    endfunction

    function automatic longint get_det(input int sel);
        if (sel == 4) return longint'(det16);
        return longint'(det8[sel]);
    endfunction

    // Brute force over all n^n index tuples; sign from inversion count.
    function automatic longint det_model(input int n, input int dw, input mat_t m);
        longint acc, mask, prod;
        int     total, v, inv;
        int     p [6];
        bit     ok;
        mask  = (longint'(1) << dw) - 1;
        acc   = 0;
        total = 1;
        for (int i = 0; i < n; i++) total *= n;
        for (int t = 0; t < total; t++) begin
            v   = t;
            ok  = 1'b1;
            inv = 0;
            for (int r = 0; r < n; r++) begin
                p[r] = v % n;
                v    = v / n;
            end
            for (int r = 0; r < n; r++)
                for (int s = 0; s < r; s++) begin
                    if (p[s] == p[r]) ok = 1'b0;
                    else if (p[s] > p[r]) inv++;
                end
            if (ok) begin
                prod = 1;
                for (int r = 0; r < n; r++) prod = (prod * longint'(m[r][p[r]])) & mask;
                acc = (inv % 2 == 1) ? acc - prod : acc + prod;
            end
        end
        return acc & mask;
    endfunction

    function automatic mat_t diag4(input int d0, input int d1, input int d2, input int d3);
        mat_t m = '{default: 0};
        m[0][0] = d0; m[1][1] = d1; m[2][2] = d2; m[3][3] = d3;
        return m;
    endfunction

    task automatic send(input int sel, input mat_t m, input longint exp);
        int n, dw, waited;
        n  = n_of(sel);
        dw = dw_of(sel);
        waited = 0;
        a_bus[sel] = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                a_bus[sel][(r*n + c)*dw +: 16] = 16'(m[r][c] & ((1 << dw) - 1));
        sb.push_back('{sel, exp, fact_i(n) * n});
        @(negedge clk);
        in_valid[sel] = 1'b1;
        while (!in_ready[sel] && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready[sel]) begin
            check("accept_timeout", 0, 1);
            in_valid[sel] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t0[sel] = cyc;
        in_valid[sel] = 1'b0;
        a_bus[sel] = '1;
    endtask

    task automatic collect(input int sel, input int hold);
        exp_t   e;
        longint d0;
        int     waited;
        bit     bad;
        waited = 0;
        bad    = 1'b0;
        out_ready[sel] = (hold == 0);
        while (!out_valid[sel] && waited < 5000) begin
            @(negedge clk);
            waited++;
            if (!out_valid[sel] && in_ready[sel]) bad = 1'b1;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (!out_valid[sel]) begin
            check("out_valid_timeout", 0, 1);
            out_ready[sel] = 1'b1;
            return;
        end
        check("in_ready_low_busy", bad, 0);
        check("latency", cyc - t0[sel], e.lat);
        check("det", get_det(sel), e.det);
        if (hold > 0) begin
            d0  = get_det(sel);
            bad = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                if (!out_valid[sel] || get_det(sel) != d0 || in_ready[sel]) bad = 1'b1;
            end
            check("hold_stable", bad, 0);
            out_ready[sel] = 1'b1;
        end
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        @(negedge clk);
        check("out_valid_drop", out_valid[sel], 0);
        check("in_ready_idle", in_ready[sel], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mat_t m;
        int   acc_t, n, dw, bad;
        int   nvec [5] = '{40, 40, 20, 6, 10};
        for (int s = 0; s < 5; s++) begin
            in_valid[s]  = 1'b0;
            out_ready[s] = 1'b1;
            a_bus[s]     = '0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            check("rst_in_ready", in_ready[s], 1);
            check("rst_out_valid", out_valid[s], 0);
            check("rst_det", get_det(s), 0);
        end
        rst = 1'b0;

        // Identity, N=4: det 1 after 96 cycles.
        send(2, diag4(1, 1, 1, 1), 1);
        collect(2, 0);

        // Lower-triangular and its row swap.
        m = '{default: 0};
        m[0][0] = 2; m[1][1] = 3; m[2][2] = 1; m[3][0] = 1; m[3][3] = 5;
        send(2, m, 30);
        collect(2, 0);
        m = '{default: 0};
        m[1][0] = 2; m[0][1] = 3; m[2][2] = 1; m[3][0] = 1; m[3][3] = 5;
        send(2, m, 226);
        collect(2, 0);

        // Equal rows 0 and 2.
        for (int c = 0; c < 4; c++) begin
            m[0][c] = $urandom_range(0, 255);
            m[1][c] = $urandom_range(0, 255);
            m[2][c] = m[0][c];
            m[3][c] = $urandom_range(0, 255);
        end
        send(2, m, 0);
        collect(2, 0);

        // N=3 reference matrix, latency 18.
        m = '{default: 0};
        m[0][0] = 1; m[0][1] = 2; m[0][2] = 3;
        m[1][0] = 4; m[1][1] = 5; m[1][2] = 6;
        m[2][0] = 7; m[2][1] = 8; m[2][2] = 10;
        send(1, m, 253);
        collect(1, 0);

        // Modular wrap.
        send(2, diag4(16, 16, 1, 1), 0);
        collect(2, 0);
        send(2, diag4(15, 17, 1, 1), 255);
        collect(2, 0);
        send(4, diag4(16, 16, 1, 1), 256);
        collect(4, 0);

        // Back-pressure with the next matrix already offered during DONE.
        send(2, diag4(3, 5, 7, 1), 105);
        fork
            collect(2, 10);
            begin
                repeat (90) @(negedge clk);
                send(2, diag4(2, 2, 2, 2), 16);
            end
        join
        check("accept_after_handshake", t0[2], hs_cyc + 1);
        collect(2, 0);

        // Reset 40 cycles into RUN.
        send(2, diag4(1, 1, 1, 1), 1);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #2;
        check("midrun_rst_in_ready", in_ready[2], 1);
        check("midrun_rst_out_valid", out_valid[2], 0);
        check("midrun_rst_det", get_det(2), 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete(sb.size() - 1);
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (out_valid[2] || !in_ready[2] || get_det(2) != 0) bad = 1;
        end
        check("midrun_rst_quiet", bad, 0);
        send(2, diag4(2, 3, 4, 5), 120);
        collect(2, 0);

        // Random matrices against the brute-force model.
        for (int s = 0; s < 5; s++) begin
            n  = n_of(s);
            dw = dw_of(s);
            for (int v = 0; v < nvec[s]; v++) begin
                m = '{default: 0};
                for (int r = 0; r < n; r++)
                    for (int c = 0; c < n; c++)
                        m[r][c] = int'($urandom_range(0, (1 << dw) - 1));
                send(s, m, det_model(n, dw, m));
                collect(s, 0);
            end
        end

        acc_t = sb.size();
        check("scoreboard_drained", acc_t, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
